carrier_wipeoff_integrator: RTL and testbench
=============================================

Name: carrier_wipeoff_integrator

Overview:
- Downstream consumer of the Doppler carrier NCO's 1-bit LO outputs (lo_i, lo_q).
- Multiplies each 1-bit IF sample by the LO pair and a 1-bit PRN code replica (carrier and code wipeoff).
- Integrates the I and Q products over a programmable number of samples, then dumps the sums to the tracking loops.
- Sits between the NCO / code generator and the loop-filter / discriminator logic.

Parameters:
ACC_W, 16, accumulator and output width (signed)
LEN_W, 14, width of the integration-length counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
en  in  1  sample strobe; inputs below valid when high
if_bit  in  1  IF sample, 1 = +1, 0 = -1
lo_i  in  1  NCO in-phase LO, 1 = +1, 0 = -1
lo_q  in  1  NCO quadrature LO, 1 = +1, 0 = -1
code_bit  in  1  prompt PRN chip, 1 = +1, 0 = -1
start  in  1  pulse: begin integrating (IDLE only)
stop  in  1  pulse: abort, discard partial sums
continuous  in  1  1 = auto-restart after each dump
dump_len  in  LEN_W  samples per integration, latched on start
busy  out  1  high in RUN
i_sum  out  ACC_W  signed I integration result
q_sum  out  ACC_W  signed Q integration result
dump_valid  out  1  one-cycle pulse: i_sum/q_sum/sat updated
sat  out  1  a saturation occurred during the dumped interval

Behaviour:
- Reset (rst low, async): state IDLE; accumulators, counter, len_reg, i_sum, q_sum = 0; dump_valid, busy, sat = 0.
- Product rule: p_i = +1 if (if_bit ^ lo_i ^ code_bit) == 1, else -1. p_q is the same with lo_q.
- States: IDLE, RUN.
- IDLE, start=1 and dump_len != 0:
  - latch len_reg = dump_len.
  - clear accumulators, counter and sticky-sat.
  - go to RUN; busy = 1 from the next cycle.
- IDLE, start with dump_len == 0: ignored, stay IDLE.
- IDLE, en: ignored.
- RUN, en=1: acc_i += p_i, acc_q += p_q, counter += 1. en=0: hold all state. Gaps in en are legal.
- Terminal sample: en=1 and counter == len_reg-1. At that clock edge:
  - i_sum/q_sum = acc + p (the final sums).
  - sat = sticky-sat OR'd with any saturation on this sample.
  - dump_valid = 1 for exactly the following cycle.
  - accumulators, counter and sticky-sat clear to 0.
  - continuous=1: stay in RUN, next en sample starts a new interval. No sample is lost.
  - continuous=0: go to IDLE, busy = 0.
- Dump latency: 1 clock from the terminal en cycle to dump_valid high.
- i_sum/q_sum/sat hold their values until the next dump.
- Saturation:
  - Accumulators clamp to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)]; the range is symmetric.
  - Any clamp sets sticky-sat for the current interval.
- stop in RUN: go to IDLE next cycle; accumulators/counter cleared; no dump_valid; i_sum/q_sum keep the previous dump.
- stop and terminal sample in the same cycle: the dump completes (dump_valid pulses), then IDLE regardless of continuous.
- start while in RUN: ignored.
- start and stop together in IDLE: stop wins, stay IDLE.
- dump_len changes during RUN: no effect until the next start.
- Reset mid-operation: immediate return to reset values; no dump pulse.

Test Plan:
- Aligned dump: dump_len=4, continuous=0, 4 en cycles with if_bit=lo_i=lo_q=code_bit=1 -> one cycle after the 4th en: dump_valid=1, i_sum=+4, q_sum=+4, sat=0; busy falls and state returns to IDLE.
- Quadrature sign: dump_len=8, lo_q=0, other inputs 1 -> i_sum=+8, q_sum=-8. Then code_bit alternating 1,0 -> i_sum=0, q_sum=0.
- en gaps and continuous mode: dump_len=3, continuous=1, en asserted every other cycle for 9 samples, all +1 products -> exactly 3 dump_valid pulses, each i_sum=+3; busy stays 1; no sample dropped between intervals.
- Saturation with ACC_W=4: dump_len=10, all +1 products -> i_sum=+7, q_sum=+7, sat=1. The next interval of 4 samples gives i_sum=+4, sat=0.
- Abort: dump_len=6, stop after 3 samples -> no dump_valid, IDLE, i_sum unchanged. Then stop coincident with the 6th sample of a new run (continuous=1) -> dump_valid=1, then IDLE.
- Reset mid-run: rst low after 2 of 5 samples -> all outputs 0 immediately. A new start with dump_len=5 gives a clean i_sum=+5.

Source files
------------

// File: rtl/carrier_wipeoff_integrator.sv
// Carrier and code wipeoff followed by an integrate-and-dump stage.
// Each enabled sample is mixed with the 1-bit LO pair and prompt PRN chip.
// The +/-1 products are summed into symmetric saturating accumulators and
// dumped to the tracking loops after a programmable number of samples.
module carrier_wipeoff_integrator #(
   parameter int ACC_W = 16,
   parameter int LEN_W = 14
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    if_bit,
   input  logic                    lo_i,
   input  logic                    lo_q,
   input  logic                    code_bit,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    continuous,
   input  logic [LEN_W-1:0]        dump_len,
   output logic                    busy,
   output logic signed [ACC_W-1:0] i_sum,
   output logic signed [ACC_W-1:0] q_sum,
   output logic                    dump_valid,
   output logic                    sat
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic signed [ACC_W:0] POS_LIM  = (ACC_W+1)'(2**(ACC_W-1) - 1);
   localparam logic signed [ACC_W:0] NEG_LIM  = -POS_LIM;
   localparam logic signed [ACC_W:0] STEP_POS = (ACC_W+1)'(1);
   localparam logic signed [ACC_W:0] STEP_NEG = (ACC_W+1)'(-1);

   // True when a widened sum lies outside the symmetric accumulator range.
   function automatic logic out_of_range(input logic signed [ACC_W:0] x);
      return (x > POS_LIM) || (x < NEG_LIM);
   endfunction

   // Clamp a widened sum back into the symmetric accumulator range.
   function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W:0] x);
      logic signed [ACC_W:0] y;
      if (x > POS_LIM)      y = POS_LIM;
      else if (x < NEG_LIM) y = NEG_LIM;
      else                  y = x;
      return y[ACC_W-1:0];
   endfunction

   state_t                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
   logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic                    sticky_q, sticky_d;
   logic signed [ACC_W-1:0] i_sum_q, i_sum_d;
   logic signed [ACC_W-1:0] q_sum_q, q_sum_d;
   logic                    sat_q, sat_d;
   logic                    dump_valid_q, dump_valid_d;

   logic signed [ACC_W:0]   sum_i_w, sum_q_w;
   logic                    sat_now;
   logic                    terminal;

   // Wipeoff products (XOR of +/-1 bits) added to the widened accumulators.
   always_comb begin
      sum_i_w  = $signed({acc_i_q[ACC_W-1], acc_i_q})
               + ((if_bit ^ lo_i ^ code_bit) ? STEP_POS : STEP_NEG);
      sum_q_w  = $signed({acc_q_q[ACC_W-1], acc_q_q})
               + ((if_bit ^ lo_q ^ code_bit) ? STEP_POS : STEP_NEG);
      sat_now  = out_of_range(sum_i_w) || out_of_range(sum_q_w);
      terminal = (state_q == RUN) && en && (cnt_q == len_q - LEN_W'(1));
   end

   // Next-state logic for the IDLE/RUN controller and the integrators.
   always_comb begin
      state_d      = state_q;
      acc_i_d      = acc_i_q;
      acc_q_d      = acc_q_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      sticky_d     = sticky_q;
      i_sum_d      = i_sum_q;
      q_sum_d      = q_sum_q;
      sat_d        = sat_q;
      dump_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            // stop has priority over start; a zero length is never started
            if (!stop && start && (dump_len != '0)) begin
               len_d    = dump_len;
               acc_i_d  = '0;
               acc_q_d  = '0;
               cnt_d    = '0;
               sticky_d = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (terminal) begin
               // the final sample is folded straight into the dumped sums
               i_sum_d      = clamp(sum_i_w);
               q_sum_d      = clamp(sum_q_w);
               sat_d        = sticky_q || sat_now;
               dump_valid_d = 1'b1;
               acc_i_d      = '0;
               acc_q_d      = '0;
               cnt_d        = '0;
               sticky_d     = 1'b0;
               if (stop || !continuous) state_d = IDLE;
            end else if (stop) begin
               acc_i_d  = '0;
               acc_q_d  = '0;
               cnt_d    = '0;
               sticky_d = 1'b0;
               state_d  = IDLE;
            end else if (en) begin
               acc_i_d  = clamp(sum_i_w);
               acc_q_d  = clamp(sum_q_w);
               cnt_d    = cnt_q + LEN_W'(1);
               sticky_d = sticky_q || sat_now;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         acc_i_q      <= '0;
         acc_q_q      <= '0;
         cnt_q        <= '0;
         len_q        <= '0;
         sticky_q     <= 1'b0;
         i_sum_q      <= '0;
         q_sum_q      <= '0;
         sat_q        <= 1'b0;
         dump_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_i_q      <= acc_i_d;
         acc_q_q      <= acc_q_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         sticky_q     <= sticky_d;
         i_sum_q      <= i_sum_d;
         q_sum_q      <= q_sum_d;
         sat_q        <= sat_d;
         dump_valid_q <= dump_valid_d;
      end
   end

   assign busy       = (state_q == RUN);
   assign i_sum      = i_sum_q;
   assign q_sum      = q_sum_q;
   assign sat        = sat_q;
   assign dump_valid = dump_valid_q;

endmodule

// File: tb/tb_carrier_wipeoff_integrator.sv
// Directed bench for carrier_wipeoff_integrator: a 16-bit instance for the
// general behaviour and a 4-bit instance for the saturation interval.
module tb_carrier_wipeoff_integrator;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        if_bit = 1'b1;
   logic        lo_i = 1'b1;
   logic        lo_q = 1'b1;
   logic        code_bit = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        continuous = 1'b0;
   logic [13:0] dump_len = '0;

   logic               busy, dump_valid, sat;
   logic signed [15:0] i_sum, q_sum;
   logic               busy_s, dump_valid_s, sat_s;
   logic signed [3:0]  i_sum_s, q_sum_s;

   int checks = 0;
   int errors = 0;

   carrier_wipeoff_integrator #(.ACC_W(16), .LEN_W(14)) dut (
      .clk(clk), .rst(rst), .en(en), .if_bit(if_bit), .lo_i(lo_i), .lo_q(lo_q),
      .code_bit(code_bit), .start(start), .stop(stop), .continuous(continuous),
      .dump_len(dump_len), .busy(busy), .i_sum(i_sum), .q_sum(q_sum),
      .dump_valid(dump_valid), .sat(sat)
   );

   carrier_wipeoff_integrator #(.ACC_W(4), .LEN_W(14)) dut_s (
      .clk(clk), .rst(rst), .en(en), .if_bit(if_bit), .lo_i(lo_i), .lo_q(lo_q),
      .code_bit(code_bit), .start(start), .stop(stop), .continuous(continuous),
      .dump_len(dump_len), .busy(busy_s), .i_sum(i_sum_s), .q_sum(q_sum_s),
      .dump_valid(dump_valid_s), .sat(sat_s)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_run(input logic [13:0] len, input logic cont);
      dump_len   = len;
      continuous = cont;
      start      = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic sample(input logic ib, input logic li, input logic lq, input logic cb);
      en = 1'b1; if_bit = ib; lo_i = li; lo_q = lq; code_bit = cb;
      tick();
      en = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (i_sum !== 16'sd0) begin errors++; $display("FAIL reset_i_sum got %0d want 0", i_sum); end
      checks++; if (q_sum !== 16'sd0) begin errors++; $display("FAIL reset_q_sum got %0d want 0", q_sum); end
      checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL reset_dump_valid got %0b want 0", dump_valid); end
      checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %0b want 0", sat); end
      #3 rst = 1'b1;
      tick();
   endtask

   task automatic test_idle_controls();
      begin_run(14'd0, 1'b0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_len_start busy got %0b want 0", busy); end
      stop = 1'b1;
      begin_run(14'd4, 1'b0);
      stop = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_idle busy got %0b want 0", busy); end
   endtask

   task automatic test_aligned();
      logic early;
      early = 1'b0;
      begin_run(14'd4, 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL aligned_busy got %0b want 1", busy); end
      for (int k = 0; k < 3; k++) begin
         sample(1, 1, 1, 1);
         if (dump_valid !== 1'b0) early = 1'b1;
      end
      checks++; if (early) begin errors++; $display("FAIL aligned_early_dump got 1 want 0"); end
      sample(1, 1, 1, 1);
      checks++; if (dump_valid !== 1'b1) begin errors++; $display("FAIL aligned_dump_valid got %0b want 1", dump_valid); end
      checks++; if (i_sum !== 16'sd4) begin errors++; $display("FAIL aligned_i_sum got %0d want 4", i_sum); end
      checks++; if (q_sum !== 16'sd4) begin errors++; $display("FAIL aligned_q_sum got %0d want 4", q_sum); end
      checks++; if (sat !== 1'b0) begin errors++; $display("FAIL aligned_sat got %0b want 0", sat); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL aligned_busy_fall got %0b want 0", busy); end
      tick();
      checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL aligned_pulse_width got %0b want 0", dump_valid); end
      checks++; if (i_sum !== 16'sd4) begin errors++; $display("FAIL aligned_hold got %0d want 4", i_sum); end
   endtask

   task automatic test_quadrature();
      begin_run(14'd8, 1'b0);
      for (int k = 0; k < 8; k++) sample(1, 1, 0, 1);
      checks++; if (i_sum !== 16'sd8) begin errors++; $display("FAIL quad_i_sum got %0d want 8", i_sum); end
      checks++; if (q_sum !== -16'sd8) begin errors++; $display("FAIL quad_q_sum got %0d want -8", q_sum); end
      begin_run(14'd8, 1'b0);
      for (int k = 0; k < 8; k++) sample(1, 1, 0, (k % 2 == 0) ? 1'b1 : 1'b0);
      checks++; if (dump_valid !== 1'b1) begin errors++; $display("FAIL alt_dump_valid got %0b want 1", dump_valid); end
      checks++; if (i_sum !== 16'sd0) begin errors++; $display("FAIL alt_i_sum got %0d want 0", i_sum); end
      checks++; if (q_sum !== 16'sd0) begin errors++; $display("FAIL alt_q_sum got %0d want 0", q_sum); end
   endtask

   task automatic test_continuous();
      int pulses;
      logic bad_sum, busy_drop;
      pulses = 0; bad_sum = 1'b0; busy_drop = 1'b0;
      begin_run(14'd3, 1'b1);
      for (int k = 0; k < 9; k++) begin
         sample(1, 1, 1, 1);
         if (dump_valid === 1'b1) begin
            pulses++;
            if (i_sum !== 16'sd3) bad_sum = 1'b1;
         end
         if (busy !== 1'b1) busy_drop = 1'b1;
         tick();
         if (dump_valid === 1'b1) pulses++;
         if (busy !== 1'b1) busy_drop = 1'b1;
      end
      checks++; if (pulses != 3) begin errors++; $display("FAIL cont_pulses got %0d want 3", pulses); end
      checks++; if (bad_sum) begin errors++; $display("FAIL cont_i_sum got non-3 want 3"); end
      checks++; if (busy_drop) begin errors++; $display("FAIL cont_busy got 0 want 1"); end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy got %0b want 0", busy); end
   endtask

   task automatic test_saturation();
      begin_run(14'd10, 1'b0);
      for (int k = 0; k < 10; k++) sample(1, 1, 1, 1);
      checks++; if (dump_valid_s !== 1'b1) begin errors++; $display("FAIL sat_dump_valid got %0b want 1", dump_valid_s); end
      checks++; if (i_sum_s !== 4'sd7) begin errors++; $display("FAIL sat_i_sum got %0d want 7", i_sum_s); end
      checks++; if (q_sum_s !== 4'sd7) begin errors++; $display("FAIL sat_q_sum got %0d want 7", q_sum_s); end
      checks++; if (sat_s !== 1'b1) begin errors++; $display("FAIL sat_flag got %0b want 1", sat_s); end
      checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL sat_busy got %0b want 0", busy_s); end
      checks++; if (i_sum !== 16'sd10) begin errors++; $display("FAIL wide_i_sum got %0d want 10", i_sum); end
      begin_run(14'd4, 1'b0);
      for (int k = 0; k < 4; k++) sample(1, 1, 1, 1);
      checks++; if (i_sum_s !== 4'sd4) begin errors++; $display("FAIL sat_next_i_sum got %0d want 4", i_sum_s); end
      checks++; if (sat_s !== 1'b0) begin errors++; $display("FAIL sat_next_flag got %0b want 0", sat_s); end
   endtask

   task automatic test_abort();
      logic saw_dump;
      saw_dump = 1'b0;
      begin_run(14'd6, 1'b0);
      for (int k = 0; k < 3; k++) sample(1, 1, 1, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      if (dump_valid !== 1'b0) saw_dump = 1'b1;
      tick();
      if (dump_valid !== 1'b0) saw_dump = 1'b1;
      checks++; if (saw_dump) begin errors++; $display("FAIL abort_dump got 1 want 0"); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
      checks++; if (i_sum !== 16'sd4) begin errors++; $display("FAIL abort_i_hold got %0d want 4", i_sum); end
      begin_run(14'd6, 1'b1);
      for (int k = 0; k < 5; k++) sample(1, 1, 1, 1);
      stop = 1'b1;
      sample(1, 1, 1, 1);
      stop = 1'b0;
      checks++; if (dump_valid !== 1'b1) begin errors++; $display("FAIL stop_term_dump got %0b want 1", dump_valid); end
      checks++; if (i_sum !== 16'sd6) begin errors++; $display("FAIL stop_term_i_sum got %0d want 6", i_sum); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_term_busy got %0b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      begin_run(14'd5, 1'b0);
      for (int k = 0; k < 2; k++) sample(1, 1, 1, 1);
      #2 rst = 1'b0;
      #1;
      checks++; if (i_sum !== 16'sd0) begin errors++; $display("FAIL rmid_i_sum got %0d want 0", i_sum); end
      checks++; if (q_sum !== 16'sd0) begin errors++; $display("FAIL rmid_q_sum got %0d want 0", q_sum); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", busy); end
      checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL rmid_dump_valid got %0b want 0", dump_valid); end
      checks++; if (sat_s !== 1'b0) begin errors++; $display("FAIL rmid_sat got %0b want 0", sat_s); end
      tick();
      rst = 1'b1;
      tick();
      begin_run(14'd5, 1'b0);
      for (int k = 0; k < 5; k++) sample(1, 1, 1, 1);
      checks++; if (i_sum !== 16'sd5) begin errors++; $display("FAIL rmid_restart_i_sum got %0d want 5", i_sum); end
      checks++; if (dump_valid !== 1'b1) begin errors++; $display("FAIL rmid_restart_dump got %0b want 1", dump_valid); end
   endtask

   initial begin
      #2;
      test_reset();
      test_idle_controls();
      test_aligned();
      test_quadrature();
      test_continuous();
      test_saturation();
      test_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
